// File: rtl/mem_stage.sv
// Memory stage: load/store/push/pop over a single-outstanding req/ack data-memory port,
// owns the stack pointer and produces the write-back result for the register file.
module mem_stage #(
  parameter logic [31:0] STACK_BASE  = 32'h0000_0400,
  parameter logic [31:0] STACK_LIMIT = 32'h0000_0300,
  parameter int unsigned TIMEOUT     = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        in_valid,
  input  logic [2:0]  mem_op,
  input  logic [31:0] ex_result,
  input  logic [31:0] store_data,
  input  logic [4:0]  rd_in,
  input  logic        wb_in,
  output logic        stall,
  output logic        out_valid,
  output logic [31:0] wb_data,
  output logic [4:0]  rd_out,
  output logic        wb_en,
  output logic        mem_error,
  output logic [31:0] stack_top,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ack
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT);

  typedef enum logic {IDLE, REQ} state_e;

  typedef enum logic [2:0] {
    OP_NONE  = 3'b000,
    OP_LOAD  = 3'b001,
    OP_STORE = 3'b010,
    OP_PUSH  = 3'b011,
    OP_POP   = 3'b100
  } op_e;

  state_e           state_q, state_d;
  logic [2:0]       op_q, op_d;
  logic [4:0]       rd_q, rd_d;
  logic             wb_q, wb_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      sp_q, sp_d;
  logic             out_valid_q, out_valid_d;
  logic [31:0]      wb_data_q, wb_data_d;
  logic [4:0]       rd_out_q, rd_out_d;
  logic             wb_en_q, wb_en_d;
  logic             mem_error_q, mem_error_d;
  logic             req_q, req_d;
  logic             we_q, we_d;
  logic [31:0]      addr_q, addr_d;
  logic [31:0]      wdata_q, wdata_d;

  logic is_load, is_store, is_push, is_pop, is_mem, bound_err, op_returns_data;

  always_comb begin
    is_load   = (mem_op == OP_LOAD);
    is_store  = (mem_op == OP_STORE);
    is_push   = (mem_op == OP_PUSH);
    is_pop    = (mem_op == OP_POP);
    is_mem    = is_load | is_store | is_push | is_pop;
    bound_err = (is_push && (sp_q == STACK_LIMIT)) || (is_pop && (sp_q == STACK_BASE));
    op_returns_data = (op_q == OP_LOAD) || (op_q == OP_POP);
  end

  // NOTE: every signal gets a default before the case so no path leaves one unassigned
  // (which would infer a latch).
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    rd_d        = rd_q;
    wb_d        = wb_q;
    cnt_d       = cnt_q;
    sp_d        = sp_q;
    out_valid_d = 1'b0;
    wb_data_d   = wb_data_q;
    rd_out_d    = rd_out_q;
    wb_en_d     = 1'b0;
    mem_error_d = 1'b0;
    req_d       = req_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    stall       = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          if (bound_err) begin
            out_valid_d = 1'b1;
            mem_error_d = 1'b1;
            wb_data_d   = '0;
            rd_out_d    = rd_in;
          end else if (is_mem) begin
            stall   = 1'b1;
            state_d = REQ;
            op_d    = mem_op;
            rd_d    = rd_in;
            wb_d    = wb_in;
            cnt_d   = CNT_W'(1);
            req_d   = 1'b1;
            we_d    = is_store | is_push;
            wdata_d = store_data;
            if (is_push)     addr_d = sp_q - 32'd1;
            else if (is_pop) addr_d = sp_q;
            else             addr_d = ex_result;
          end else begin
            out_valid_d = 1'b1;
            wb_data_d   = ex_result;
            wb_en_d     = wb_in;
            rd_out_d    = rd_in;
          end
        end
      end

      REQ: begin
        // An ack in the final counted cycle still completes the access.
        if (dmem_ack) begin
          state_d     = IDLE;
          req_d       = 1'b0;
          we_d        = 1'b0;
          out_valid_d = 1'b1;
          rd_out_d    = rd_q;
          wb_data_d   = op_returns_data ? dmem_rdata : '0;
          wb_en_d     = op_returns_data & wb_q;
          if (op_q == OP_PUSH) sp_d = sp_q - 32'd1;
          if (op_q == OP_POP)  sp_d = sp_q + 32'd1;
        end else if (cnt_q == CNT_LAST) begin
          state_d     = IDLE;
          req_d       = 1'b0;
          we_d        = 1'b0;
          out_valid_d = 1'b1;
          mem_error_d = 1'b1;
          rd_out_d    = rd_q;
          wb_data_d   = '0;
        end else begin
          stall = 1'b1;
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q     <= IDLE;
      op_q        <= OP_NONE;
      rd_q        <= '0;
      wb_q        <= 1'b0;
      cnt_q       <= '0;
      sp_q        <= STACK_BASE;
      out_valid_q <= 1'b0;
      wb_data_q   <= '0;
      rd_out_q    <= '0;
      wb_en_q     <= 1'b0;
      mem_error_q <= 1'b0;
      req_q       <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      rd_q        <= rd_d;
      wb_q        <= wb_d;
      cnt_q       <= cnt_d;
      sp_q        <= sp_d;
      out_valid_q <= out_valid_d;
      wb_data_q   <= wb_data_d;
      rd_out_q    <= rd_out_d;
      wb_en_q     <= wb_en_d;
      mem_error_q <= mem_error_d;
      req_q       <= req_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign wb_data    = wb_data_q;
  assign rd_out     = rd_out_q;
  assign wb_en      = wb_en_q;
  assign mem_error  = mem_error_q;
  assign stack_top  = sp_q;
  assign dmem_req   = req_q;
  assign dmem_we    = we_q;
  assign dmem_addr  = addr_q;
  assign dmem_wdata = wdata_q;

endmodule
